// File: rtl/timer_responder_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// FSM state encoding and MODE field codes.
package timer_responder_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

endpackage

// File: rtl/timer_responder_byte_merge.sv
// Byte-lane merge: each output byte takes wdata when its enable is set,
// otherwise keeps the old register byte.
module byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged[8*gi +: 8] = byteen[gi] ? wdata[8*gi +: 8] : old_word[8*gi +: 8];
    end

endmodule

// File: rtl/timer_responder.sv
// Countdown timer responder on the CPU data bus: CTRL / PRESET / COUNT
// registers, a four-state count FSM and a maskable interrupt line.
module timer_responder
    import timer_responder_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_7F00,
    parameter int          CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_e           state_q, state_d;
    logic             irq_flag_q, irq_flag_d;

    logic [1:0]  off;
    logic        wr_en, ctrl_wr, preset_wr;
    logic [31:0] ctrl_merged, preset_merged;
    logic        sig_unused;

    // Word offset relative to BASE, so a BASE not aligned to 16 bytes still decodes.
    assign off       = addr[3:2] - BASE[3:2];
    assign wr_en     = sel && (byteen != 4'b0000);
    assign ctrl_wr   = wr_en && (off == OFF_CTRL);
    assign preset_wr = wr_en && (off == OFF_PRESET);

    byte_merge u_ctrl_merge (
        .old_word ({28'b0, ctrl_q}),
        .wdata    (wdata),
        .byteen   (byteen),
        .merged   (ctrl_merged)
    );

    byte_merge u_preset_merge (
        .old_word (32'(preset_q)),
        .wdata    (wdata),
        .byteen   (byteen),
        .merged   (preset_merged)
    );

    assign sig_unused = ^{addr[31:4], addr[1:0], ctrl_merged[31:4], preset_merged};

    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        state_d    = state_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q[0]) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (count_q > CNT_W'(1)) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                state_d = IDLE;
                if (ctrl_q[2:1] == MODE_RELOAD) irq_flag_d = 1'b0;
                else                            ctrl_d[0]  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Bus writes override the FSM's own CTRL update and always clear the flag.
        if (ctrl_wr) begin
            ctrl_d     = ctrl_merged[3:0];
            irq_flag_d = 1'b0;
        end
        if (preset_wr) preset_d = preset_merged[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:   rdata = {28'b0, ctrl_q};
                OFF_PRESET: rdata = 32'(preset_q);
                OFF_COUNT:  rdata = 32'(count_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = ctrl_q[3] & irq_flag_q;

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: stimulus pushes expected read data and
// irq per checked cycle; a negedge monitor pops and compares.
module tb_timer_responder;
    import timer_responder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mon_valid = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    timer_responder #(.BASE(BASE), .CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: DUT cycle with no expected entry");
            end else begin
                mon_e = sb.pop_front();
                n_checks++;
                if (rdata !== mon_e.rd) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h expected %h", mon_e.name, rdata, mon_e.rd);
                end
                n_checks++;
                if (irq !== mon_e.irq) begin
                    n_fail++;
                    $display("FAIL %s irq: got %b expected %b", mon_e.name, irq, mon_e.irq);
                end
            end
        end
    end

    // One bus cycle; when chk is set the expected values describe this cycle's outputs.
    task automatic cyc(input logic [1:0] off, input bit s, input logic [31:0] wd,
                       input logic [3:0] be, input bit chk, input logic [31:0] exp_rd,
                       input logic exp_irq, input string name);
        sel    = s;
        addr   = BASE + {28'b0, off, 2'b00};
        wdata  = wd;
        byteen = be;
        if (chk) begin
            sb.push_back('{exp_rd, exp_irq, name});
            mon_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        mon_valid = 1'b0;
        sel       = 1'b0;
        byteen    = 4'b0000;
    endtask

    task automatic rd(input logic [1:0] off, input logic [31:0] exp_rd,
                      input logic exp_irq, input string name);
        cyc(off, 1'b1, 32'h0, 4'b0000, 1'b1, exp_rd, exp_irq, name);
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        cyc(off, 1'b1, d, be, 1'b0, 32'h0, 1'b0, "");
    endtask

    task automatic do_reset(input string name);
        reset = 1'b0;
        rd(OFF_COUNT, 32'h0, 1'b0, name);
        rd(OFF_CTRL, 32'h0, 1'b0, name);
        rd(OFF_PRESET, 32'h0, 1'b0, name);
        reset = 1'b1;
        rd(OFF_COUNT, 32'h0, 1'b0, name);
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] d,
                                                input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) mask = mask | (32'hFF << (8 * i));
        return (old & ~mask) | (d & mask);
    endfunction

    // Reference timeline after a CTRL write that sets EN (edge T0): j counts edges
    // after T0. Counting starts at T0+2 from PRESET (0 behaves as 1) and fires at
    // T0+2+N'; auto-reload repeats with period N'+3, one-shot clears EN one edge later.
    task automatic check_run(input int n, input logic [3:0] cv, input logic [31:0] old,
                             input int len, input string name);
        int          np, fire, p;
        logic [31:0] cnt;
        logic        irqe;
        logic [3:0]  ctrlv;
        bit          reload;
        np     = (n == 0) ? 1 : n;
        fire   = 2 + np;
        reload = (cv[2:1] == MODE_RELOAD);
        for (int j = 0; j < len; j++) begin
            ctrlv = cv;
            irqe  = 1'b0;
            if (j < 2) begin
                cnt = old;
            end else if (reload) begin
                p    = (j - 2) % (np + 3);
                cnt  = (p < np) ? 32'(n - p) : 32'd0;
                irqe = (p == np) && cv[3];
            end else begin
                cnt  = (j < fire) ? 32'(n - (j - 2)) : 32'd0;
                irqe = (j >= fire) && cv[3];
                if (j > fire) ctrlv[0] = 1'b0;
            end
            if (j % 2 == 0) rd(OFF_COUNT, cnt, irqe, name);
            else            rd(OFF_CTRL, {28'b0, ctrlv}, irqe, name);
        end
    endtask

    initial begin
        logic [31:0] d, exp_p;
        logic [3:0]  be, cv;
        int          n, np, len;

        reset  = 1'b0;
        sel    = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        byteen = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rd(OFF_CTRL, 32'h0, 1'b0, "reset_ctrl");
        rd(OFF_PRESET, 32'h0, 1'b0, "reset_preset");
        rd(OFF_COUNT, 32'h0, 1'b0, "reset_count");

        // Reset pulse in the middle of a count
        wr(OFF_PRESET, 32'd10, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(10, 4'h9, 32'h0, 5, "rst_mid_run");
        do_reset("rst_mid_clear");
        repeat (3) rd(OFF_COUNT, 32'h0, 1'b0, "rst_hold");
        rd(OFF_CTRL, 32'h0, 1'b0, "rst_hold_ctrl");

        // One-shot, then a CTRL write drops the held irq
        wr(OFF_PRESET, 32'd5, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(5, 4'h9, 32'h0, 12, "oneshot");
        cyc(OFF_CTRL, 1'b1, 32'h0, 4'hF, 1'b1, 32'h8, 1'b1, "oneshot_clr_pre");
        rd(OFF_CTRL, 32'h0, 1'b0, "oneshot_clr");

        // Auto-reload, four-plus periods
        do_reset("reload_rst");
        wr(OFF_PRESET, 32'd3, 4'hF);
        wr(OFF_CTRL, 32'hB, 4'hF);
        check_run(3, 4'hB, 32'h0, 2 + 4 * 6 + 2, "reload");

        // Byte enables, read-only COUNT, deselected and unused-offset reads
        do_reset("byteen_rst");
        wr(OFF_PRESET, 32'hAABBCCDD, 4'b0101);
        rd(OFF_PRESET, 32'h00BB00DD, 1'b0, "byteen_preset");
        wr(OFF_COUNT, 32'hFFFFFFFF, 4'hF);
        rd(OFF_COUNT, 32'h0, 1'b0, "count_ro");
        cyc(OFF_PRESET, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b0, "sel0_read");
        rd(OFF_PRESET, 32'h00BB00DD, 1'b0, "sel0_nowrite");
        rd(2'd3, 32'h0, 1'b0, "off3_read");

        // Masked one-shot
        do_reset("mask_rst");
        wr(OFF_PRESET, 32'd2, 4'hF);
        wr(OFF_CTRL, 32'h1, 4'hF);
        check_run(2, 4'h1, 32'h0, 8, "mask");

        // Pause at COUNT=4, hold, then restart from PRESET
        do_reset("pause_rst");
        wr(OFF_PRESET, 32'd10, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(10, 4'h9, 32'h0, 7, "pause_run");
        cyc(OFF_CTRL, 1'b1, 32'h8, 4'hF, 1'b1, 32'h9, 1'b0, "pause_wr");
        repeat (10) rd(OFF_COUNT, 32'd4, 1'b0, "pause_hold");
        rd(OFF_CTRL, 32'h8, 1'b0, "pause_ctrl");
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(10, 4'h9, 32'd4, 4, "pause_restart");

        // CTRL write on the INT-state edge of a one-shot
        do_reset("coll_rst");
        wr(OFF_PRESET, 32'd5, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(5, 4'h9, 32'h0, 7, "coll_run");
        cyc(OFF_CTRL, 1'b1, 32'h9, 4'hF, 1'b1, 32'h9, 1'b1, "coll_wr");
        check_run(5, 4'h9, 32'h0, 12, "coll_restart");

        // CTRL write on the same edge irq_flag would be set
        do_reset("setedge_rst");
        wr(OFF_PRESET, 32'd5, 4'hF);
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(5, 4'h9, 32'h0, 6, "setedge_run");
        cyc(OFF_CTRL, 1'b1, 32'h9, 4'hF, 1'b1, 32'h9, 1'b0, "setedge_wr");
        rd(OFF_CTRL, 32'h9, 1'b0, "setedge_int");
        rd(OFF_CTRL, 32'h8, 1'b0, "setedge_after");
        rd(OFF_COUNT, 32'h0, 1'b0, "setedge_count");

        // PRESET=0 behaves as 1
        do_reset("preset0_rst");
        wr(OFF_CTRL, 32'h9, 4'hF);
        check_run(0, 4'h9, 32'h0, 8, "preset0");

        // Randomized runs
        for (int it = 0; it < 6; it++) begin
            do_reset("rand_rst");
            d     = $urandom;
            be    = 4'($urandom_range(0, 15));
            exp_p = merge_bytes(32'h0, d, be);
            wr(OFF_PRESET, d, be);
            rd(OFF_PRESET, exp_p, 1'b0, "rand_byteen");
            n  = $urandom_range(0, 12);
            cv = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
            np = (n == 0) ? 1 : n;
            len = (cv[2:1] == MODE_RELOAD) ? 2 + 3 * (np + 3) : np + 6;
            wr(OFF_PRESET, 32'(n), 4'hF);
            wr(OFF_CTRL, {28'b0, cv}, 4'hF);
            check_run(n, cv, 32'h0, len, "rand_run");
        end

        repeat (2) @(posedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_responder.md
Name: timer_responder

Overview:
- Memory-mapped countdown timer that acts as the responder on the CPU data bus (m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata).
- Raises one hardware interrupt line, which feeds one bit of the CPU's HWInt[5:0].
- Sits behind the system bridge. The bridge decodes the address range and asserts sel; this block decodes the word offset and the byte enables.
- Read data is combinational, so the CPU's M stage sees it in the same cycle.

Parameters:
- BASE, 32'h0000_7F00, byte address of register 0 (CTRL); PRESET at BASE+4, COUNT at BASE+8.
- CNT_W, 32, width of PRESET and COUNT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- sel  input  1  bridge hit: addr lies in [BASE, BASE+11].
- addr  input  32  byte address from the CPU M stage; only bits [3:2] are used.
- byteen  input  4  byte write enables; a write occurs iff sel && byteen!=0.
- wdata  input  32  write data, already lane-aligned by the CPU.
- rdata  output  32  read data for the addressed register; 0 when sel=0 or offset is 3.
- irq  output  1  interrupt request to HWInt.

Behaviour:
- Registers:
  - CTRL[3] is IM (interrupt mask, 1 = enable).
  - CTRL[2:1] is MODE: 00 = one-shot, 01 = auto-reload, 1x is reserved and treated as 00.
  - CTRL[0] is EN.
  - CTRL[31:4] read as 0.
  - PRESET is read/write. COUNT is read-only; writes to it are ignored.
- Writes are byte-granular. Each register byte i updates from wdata[8i+7:8i] when byteen[i]=1, on the rising clk edge.
- Reset (reset=0, async):
  - CTRL, PRESET and COUNT go to 0.
  - state goes to IDLE and irq_flag goes to 0.
  - rdata reflects 0 for every register; irq=0.
  - A reset mid-count aborts the count immediately.
- State machine (state register, 2 bits):
  - IDLE: COUNT holds. If EN=1, go to LOAD next cycle.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT held.
    - Else if COUNT>1, COUNT<=COUNT-1.
    - Else (COUNT is 0 or 1), COUNT<=0, irq_flag<=1, go to INT.
  - INT:
    - MODE 00: EN<=0, go to IDLE; irq_flag stays 1.
    - MODE 01: irq_flag<=0, go to IDLE. EN is still 1, so the timer reloads.
- Latency: after a CTRL write sets EN with PRESET=N≥1:
  - the write edge is T0; LOAD is T1; CNT is entered at T2;
  - COUNT reaches 1 after N-1 CNT cycles;
  - irq_flag rises at edge T2+N.
- Auto-reload period is N+3 cycles: CNT for N, then INT, IDLE, LOAD.
- PRESET=0 behaves as PRESET=1: one CNT cycle, then INT.
- irq = IM & irq_flag (combinational from registers).
  - One-shot: irq is level-held until any CTRL write clears irq_flag.
  - Auto-reload: irq is exactly a 1-cycle pulse, during the INT state.
- Simultaneous events:
  - A bus write to CTRL on the same edge as the FSM clearing EN in INT: the bus write wins (CTRL takes the written bytes).
  - The FSM state still advances per the rule above.
  - A CTRL write always clears irq_flag, even if it arrives on the same edge irq_flag would be set.
- Writing PRESET during CNT does not affect COUNT until the next LOAD.
- Clearing EN during CNT freezes COUNT. A later EN=1 goes through LOAD, so counting restarts from PRESET.
- COUNT never wraps: decrement only occurs when COUNT>1.

Decomposition:
- Shared package holds:
  - register offsets OFF_CTRL=2'd0, OFF_PRESET=2'd1, OFF_COUNT=2'd2;
  - state encodings IDLE=0, LOAD=1, CNT=2, INT=3;
  - MODE codes MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01.
- One natural sub-module, byte_merge: combinational, takes old word, wdata and byteen, returns the merged word. It is reused for CTRL and PRESET writes.

Test Plan:
- Reset pulse mid-count (PRESET=10, EN=1, reset low at cycle 5) -> COUNT=0, CTRL=0, irq=0 immediately, and they stay so after reset releases.
- One-shot: write PRESET=5, then CTRL=4'b1001 -> irq rises exactly 7 edges after the CTRL write, stays high, and CTRL reads 8 (EN cleared). A write of CTRL=0 drops irq the next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> irq is a 1-cycle pulse every 6 cycles for at least 4 periods; COUNT reads 3,2,1 sequence between pulses.
- Byte enables: PRESET=0, write wdata=32'hAABBCCDD with byteen=4'b0101 -> PRESET reads 32'h00BB00DD. A write to COUNT leaves it unchanged.
- Mask and pause: IM=0, one-shot, PRESET=2 -> irq stays 0, and rdata of CTRL shows EN=0 after expiry. Separately, clearing EN at COUNT=4 freezes COUNT at 4 for 10 cycles.
- Collision and edge cases: a CTRL write of 4'b1001 on the INT-state edge of a one-shot -> CTRL=9, irq=0 next cycle, timer restarts via LOAD. PRESET=0 -> irq after 3 edges. sel=0 reads return 0.
